// File: rtl/tow_pkg.sv
// tow_pkg: shared state encoding, LED control codes and width helper for the tug-of-war match controller.
package tow_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_WAIT,
        ST_DARK,
        ST_PLAY,
        ST_GLOAT,
        ST_MATCH_END
    } tow_state_e;

    localparam logic [1:0] LED_CTRL_IDLE = 2'b11;
    localparam logic [1:0] LED_CTRL_DARK = 2'b00;
    localparam logic [1:0] LED_CTRL_RUN  = 2'b10;

    // Bits needed to hold values 0..v-1, never less than one.
    function automatic int clog2w(input int v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/tow_tick_counter.sv
// tow_tick_counter: clearable slowen-gated up-counter with terminal-count compare.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : return count to zero on the next edge (wins over en)
//   en       : slow tick enable, advances the count
//   term     : terminal count
//   hit      : high on the en pulse that brings the count up to term
module tow_tick_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         hit
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = clr ? '0 : count_q + W'(en);
        hit     = en && (count_q + 1'b1 == term);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

endmodule

// File: rtl/tow_match_ctrl.sv
// tow_match_ctrl: best-of match controller sequencing WAIT/DARK/PLAY/GLOAT with per-player scores.
//   clk, rst     : clock, asynchronous active-high reset
//   slowen       : one-cycle slow tick enable
//   rout         : random start qualifier, used only with slowen
//   winrnd       : one-cycle round-won pulse, winner valid with it
//   winner       : round winner index
//   new_match    : restart request, honoured only at match end
//   clear        : playfield clear, low in DARK and PLAY
//   leds_on      : LED enable, low in DARK
//   led_control  : bit0 = RESET/WAIT, bit1 = not DARK
//   score        : player i at [i*SCORE_W +: SCORE_W]
//   match_over   : high in MATCH_END
//   match_winner : winner latched when a player reaches ROUNDS_TO_WIN
// Build option TOW_DARK_TIMEOUT_EN: DARK also starts play on the DARK_MAX-th slow tick.
module tow_match_ctrl #(
    parameter int NUM_PLAYERS   = 2,
    parameter int WIN_W         = 1,
    parameter int SCORE_W       = 3,
    parameter int WAIT_TICKS    = 2,
    parameter int GLOAT_TICKS   = 2,
    parameter int ROUNDS_TO_WIN = 3,
    parameter int DARK_MAX      = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           slowen,
    input  logic                           rout,
    input  logic                           winrnd,
    input  logic [WIN_W-1:0]               winner,
    input  logic                           new_match,
    output logic                           clear,
    output logic                           leds_on,
    output logic [1:0]                     led_control,
    output logic [NUM_PLAYERS*SCORE_W-1:0] score,
    output logic                           match_over,
    output logic [WIN_W-1:0]               match_winner
);

    import tow_pkg::*;

    localparam int TMAX0 = (WAIT_TICKS > GLOAT_TICKS) ? WAIT_TICKS : GLOAT_TICKS;
    localparam int TMAX  = (TMAX0 > DARK_MAX) ? TMAX0 : DARK_MAX;
    localparam int TCW   = clog2w(TMAX + 1);
    localparam logic [SCORE_W-1:0] R_TGT = SCORE_W'(ROUNDS_TO_WIN);

    tow_state_e                     state_q, state_d;
    logic [NUM_PLAYERS*SCORE_W-1:0] score_q, score_d;
    logic                           decided_q, decided_d;
    logic [WIN_W-1:0]               match_winner_q, match_winner_d;
    logic [TCW-1:0]                 term;
    logic                           tick_hit, dark_timeout, accept;
    logic [SCORE_W-1:0]             cur, nxt;

    // One counter serves every timed phase; it restarts whenever the state changes.
    tow_tick_counter #(.W(TCW)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_d != state_q),
        .en   (slowen),
        .term (term),
        .hit  (tick_hit)
    );

    always_comb
        term = (state_q == ST_WAIT)  ? TCW'(WAIT_TICKS)  :
               (state_q == ST_GLOAT) ? TCW'(GLOAT_TICKS) : TCW'(DARK_MAX);

`ifdef TOW_DARK_TIMEOUT_EN
    assign dark_timeout = tick_hit;
`else
    assign dark_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_RESET;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:     state_d = ST_WAIT;
            ST_WAIT:      state_d = tick_hit ? ST_DARK : ST_WAIT;
            // An early press beats both start conditions.
            ST_DARK:      state_d = winrnd                      ? ST_GLOAT :
                                    (slowen && rout) || dark_timeout ? ST_PLAY : ST_DARK;
            ST_PLAY:      state_d = winrnd ? ST_GLOAT : ST_PLAY;
            ST_GLOAT:     state_d = !tick_hit ? ST_GLOAT : decided_q ? ST_MATCH_END : ST_DARK;
            ST_MATCH_END: state_d = new_match ? ST_WAIT : ST_MATCH_END;
            default:      state_d = ST_RESET;
        endcase
    end

    always_comb begin
        score_d        = score_q;
        decided_d      = decided_q;
        match_winner_d = match_winner_q;
        cur            = '0;
        nxt            = '0;
        accept         = winrnd && (state_q == ST_DARK || state_q == ST_PLAY);
        // Out-of-range winners match no player and leave the scores alone.
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (accept && int'(winner) == i) begin
                cur = score_q[i*SCORE_W +: SCORE_W];
                nxt = (&cur) ? cur : cur + 1'b1;
                score_d[i*SCORE_W +: SCORE_W] = nxt;
                if (nxt == R_TGT) begin
                    decided_d      = 1'b1;
                    match_winner_d = winner;
                end
            end
        end
        if (state_q == ST_MATCH_END && new_match) begin
            score_d        = '0;
            decided_d      = 1'b0;
            match_winner_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score_q        <= '0;
            decided_q      <= 1'b0;
            match_winner_q <= '0;
        end else begin
            score_q        <= score_d;
            decided_q      <= decided_d;
            match_winner_q <= match_winner_d;
        end
    end

    always_comb begin
        clear        = !(state_q == ST_DARK || state_q == ST_PLAY);
        leds_on      = state_q != ST_DARK;
        led_control  = (state_q == ST_DARK)                           ? LED_CTRL_DARK :
                       (state_q == ST_RESET || state_q == ST_WAIT)    ? LED_CTRL_IDLE : LED_CTRL_RUN;
        match_over   = state_q == ST_MATCH_END;
        score        = score_q;
        match_winner = match_winner_q;
    end

endmodule

// File: tb/tb_tow_match_ctrl.sv
// tb_tow_match_ctrl: scoreboard bench for tow_match_ctrl against a phase-level reference model.
module tb_tow_match_ctrl;

    localparam int NP      = 3;
    localparam int WW      = 2;
    localparam int SW      = 3;
    localparam int WAIT_T  = 2;
    localparam int GLOAT_T = 2;
    localparam int RWIN    = 3;
    localparam int DMAX    = 15;
    localparam int SMAX    = (1 << SW) - 1;
`ifdef TOW_DARK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int P_RST = 0, P_WAIT = 1, P_DARK = 2, P_PLAY = 3, P_GLOAT = 4, P_MEND = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             slowen = 1'b0, rout = 1'b0, winrnd = 1'b0, new_match = 1'b0;
    logic [WW-1:0]    winner = '0;
    logic             clear, leds_on, match_over;
    logic [1:0]       led_control;
    logic [NP*SW-1:0] score;
    logic [WW-1:0]    match_winner;

    tow_match_ctrl #(
        .NUM_PLAYERS(NP), .WIN_W(WW), .SCORE_W(SW), .WAIT_TICKS(WAIT_T),
        .GLOAT_TICKS(GLOAT_T), .ROUNDS_TO_WIN(RWIN), .DARK_MAX(DMAX)
    ) dut (
        .clk(clk), .rst(rst), .slowen(slowen), .rout(rout), .winrnd(winrnd),
        .winner(winner), .new_match(new_match), .clear(clear), .leds_on(leds_on),
        .led_control(led_control), .score(score), .match_over(match_over),
        .match_winner(match_winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             clr;
        logic             leds;
        logic [1:0]       lc;
        logic [NP*SW-1:0] sc;
        logic             mo;
        logic [WW-1:0]    mw;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    bit   armed = 1'b0;

    int   ph, tk, mw_m;
    int   s[NP];
    bit   dec;

    function automatic exp_t model_out();
        exp_t e;
        e.clr  = !(ph == P_DARK || ph == P_PLAY);
        e.leds = ph != P_DARK;
        e.lc   = {ph != P_DARK, ph == P_RST || ph == P_WAIT};
        e.sc   = '0;
        for (int i = 0; i < NP; i++) e.sc[i*SW +: SW] = SW'(s[i]);
        e.mo   = ph == P_MEND;
        e.mw   = WW'(mw_m);
        return e;
    endfunction

    task automatic model_reset();
        ph = P_RST; tk = 0; dec = 0; mw_m = 0;
        for (int i = 0; i < NP; i++) s[i] = 0;
    endtask

    task automatic award(input int w);
        if (w < NP) begin
            s[w] = (s[w] + 1 > SMAX) ? SMAX : s[w] + 1;
            if (s[w] == RWIN) begin dec = 1; mw_m = w; end
        end
    endtask

    task automatic model_step(input bit sl, input bit ro, input bit wr, input int wn, input bit nm);
        int nph = ph;
        case (ph)
            P_RST:   nph = P_WAIT;
            P_WAIT:  if (sl && tk + 1 == WAIT_T) nph = P_DARK;
            P_DARK:  if (wr) begin award(wn); nph = P_GLOAT; end
                     else if (sl && ro) nph = P_PLAY;
                     else if (TO_EN && sl && tk + 1 == DMAX) nph = P_PLAY;
            P_PLAY:  if (wr) begin award(wn); nph = P_GLOAT; end
            P_GLOAT: if (sl && tk + 1 == GLOAT_T) nph = dec ? P_MEND : P_DARK;
            P_MEND:  if (nm) begin
                         nph = P_WAIT; dec = 0; mw_m = 0;
                         for (int i = 0; i < NP; i++) s[i] = 0;
                     end
            default: nph = P_RST;
        endcase
        tk = (nph != ph) ? 0 : tk + int'(sl);
        ph = nph;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic cmp_all(input exp_t e);
        chk("clear", 32'(clear), 32'(e.clr));
        chk("leds_on", 32'(leds_on), 32'(e.leds));
        chk("led_control", 32'(led_control), 32'(e.lc));
        chk("score", 32'(score), 32'(e.sc));
        chk("match_over", 32'(match_over), 32'(e.mo));
        chk("match_winner", 32'(match_winner), 32'(e.mw));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; slowen = 0; rout = 0; winrnd = 0; new_match = 0; winner = '0;
        model_reset();
        #1;
        cmp_all(model_out());
        q.push_back(model_out());
        armed = 1'b1;
    endtask

    task automatic step(input bit sl, input bit ro, input bit wr, input int wn, input bit nm);
        @(negedge clk);
        rst = 1'b0; slowen = sl; rout = ro; winrnd = wr; winner = WW'(wn); new_match = nm;
        model_step(sl, ro, wr, wn, nm);
        q.push_back(model_out());
    endtask

    task automatic idle(input int n, input bit sl);
        for (int i = 0; i < n; i++) step(sl, 0, 0, 0, 0);
    endtask

    task automatic play_win(input int w);
        step(1, 1, 0, 0, 0);
        step(0, 0, 1, w, 0);
        idle(GLOAT_T, 1);
    endtask

    initial begin
        wait (armed);
        forever begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_empty got=0 exp=1 at %0t", $time);
            end else cmp_all(q.pop_front());
        end
    end

    initial begin
        do_reset();
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        idle(2, 0);
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        idle(GLOAT_T, 1);
        step(1, 1, 1, 0, 0);
        idle(GLOAT_T, 1);
        step(1, 1, 0, 0, 0);
        step(0, 0, 1, 3, 0);
        idle(GLOAT_T, 1);
        play_win(0);
        play_win(0);
        step(1, 1, 1, 1, 0);
        idle(3, 1);
        step(0, 0, 0, 0, 1);
        idle(WAIT_T, 1);
        play_win(0);
        play_win(0);
        step(1, 1, 0, 0, 0);
        idle(2, 0);
        do_reset();
        step(0, 0, 0, 0, 0);
        idle(WAIT_T, 1);
        idle(DMAX + 1, 1);
        idle(3, 0);
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 7) == 0, int'($urandom_range(0, 3)),
                      $urandom_range(0, 15) == 0);
        end
        @(posedge clk);
        #2;
        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
